tick_timekeeper: RTL and testbench



---
 rtl/clock_pkg.sv | 45 ++++
 rtl/bcd_mod_counter.sv | 29 ++
 rtl/tick_timekeeper.sv | 110 +++++++++++
 tb/tb_tick_timekeeper.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD clock types, limits and helpers.
// Used by the timekeeper and the alarm-set logic.
package clock_pkg;

    typedef logic [7:0] bcd2_t;

    typedef struct packed {
        logic  pm;
        bcd2_t hh;
    } hour12_t;

    localparam bcd2_t BCD_59 = 8'h59;
    localparam bcd2_t BCD_23 = 8'h23;
    localparam bcd2_t BCD_12 = 8'h12;

    // Valid two-digit BCD no greater than max. For valid BCD,
    // the binary compare gives the same ordering as the decimal value.
    function automatic logic bcd_valid(input bcd2_t v, input bcd2_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd2_t bcd_next(input bcd2_t v, input bcd2_t max);
        if (v == max)
            return '0;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24 h BCD hour to 12 h BCD hour plus pm flag.
    function automatic hour12_t to_hour12(input bcd2_t h24);
        hour12_t r;
        r.pm = (h24 >= BCD_12);
        if (h24 == 8'h00 || h24 == BCD_12)
            r.hh = BCD_12;
        else if (!r.pm)
            r.hh = h24;
        else if (h24 == 8'h20 || h24 == 8'h21)
            r.hh = h24 - 8'h18;
        else
            r.hh = h24 - 8'h12;
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00, with load.
// carry flags the cycle in which an increment wraps the count.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd2_t MAX       = BCD_59,
    parameter bcd2_t RESET_VAL = 8'h00
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    always_ff @(posedge CLK100MHZ) begin
        if (reset)
            value <= RESET_VAL;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= bcd_next(value, MAX);
    end

    assign carry = inc && (value == MAX);

endmodule

// File: rtl/tick_timekeeper.sv
// BCD HH:MM:SS timekeeper advanced by rising edges of the 1 Hz strobe.
// Optional HOUR12_EN: hh is presented in 12 h form with a pm flag.
module tick_timekeeper
    import clock_pkg::*;
#(
    parameter bcd2_t RESET_HH = 8'h00,
    parameter bcd2_t RESET_MM = 8'h00,
    parameter bcd2_t RESET_SS = 8'h00
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       clk_stb,
    input  logic       hold,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_tick,
    output logic       day_roll,
    output logic       load_err
`ifdef HOUR12_EN
    ,
    output logic       pm
`endif
);

    logic  stb_q;
    logic  rise;
    logic  load_ok;
    logic  ld;
    logic  adv;
    logic  ss_carry;
    logic  mm_carry;
    logic  hh_carry;
    bcd2_t ss_v;
    bcd2_t mm_v;
    bcd2_t hh_v;

    always_comb begin
        rise    = clk_stb & ~stb_q;
        load_ok = bcd_valid(load_hh, BCD_23) && bcd_valid(load_mm, BCD_59)
                  && bcd_valid(load_ss, BCD_59);
        ld      = load & load_ok;
        // A valid load overrides the second that arrives with it.
        adv     = rise & ~hold & ~ld;
    end

    // stb_q resets high so a strobe already high at release is not an edge.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            stb_q    <= 1'b1;
            sec_tick <= 1'b0;
            day_roll <= 1'b0;
            load_err <= 1'b0;
        end else begin
            stb_q    <= clk_stb;
            sec_tick <= rise;
            day_roll <= hh_carry;
            load_err <= load & ~load_ok;
        end
    end

    bcd_mod_counter #(.MAX(BCD_59), .RESET_VAL(RESET_SS)) u_ss (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .inc(adv), .load(ld),
        .load_val(load_ss), .value(ss_v), .carry(ss_carry)
    );

    bcd_mod_counter #(.MAX(BCD_59), .RESET_VAL(RESET_MM)) u_mm (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .inc(ss_carry), .load(ld),
        .load_val(load_mm), .value(mm_v), .carry(mm_carry)
    );

    bcd_mod_counter #(.MAX(BCD_23), .RESET_VAL(RESET_HH)) u_hh (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .inc(mm_carry), .load(ld),
        .load_val(load_hh), .value(hh_v), .carry(hh_carry)
    );

    assign ss = ss_v;
    assign mm = mm_v;

`ifdef HOUR12_EN
    bcd2_t   hh_next;
    hour12_t h12_q;

    // Convert the hour's next value so the 12 h register lines up with mm/ss.
    always_comb begin
        hh_next = hh_v;
        if (ld)
            hh_next = load_hh;
        else if (mm_carry)
            hh_next = bcd_next(hh_v, BCD_23);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset)
            h12_q <= to_hour12(RESET_HH);
        else
            h12_q <= to_hour12(hh_next);
    end

    assign hh = h12_q.hh;
    assign pm = h12_q.pm;
`else
    assign hh = hh_v;
`endif

endmodule

// File: tb/tb_tick_timekeeper.sv
// Scoreboard bench for tick_timekeeper: an integer time model predicts every cycle.
// Compile with +define+HOUR12_EN to exercise the 12 h output.
module tb_tick_timekeeper;

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       clk_stb = 1'b1;
    logic       hold = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_hh = '0;
    logic [7:0] load_mm = '0;
    logic [7:0] load_ss = '0;
    logic [7:0] hh, mm, ss;
    logic       sec_tick, day_roll, load_err;
`ifdef HOUR12_EN
    logic       pm;
`endif

    always #5 CLK100MHZ = ~CLK100MHZ;

    tick_timekeeper #(.RESET_HH(8'h00), .RESET_MM(8'h00), .RESET_SS(8'h00)) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .clk_stb(clk_stb), .hold(hold),
        .load(load), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
        .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick), .day_roll(day_roll),
        .load_err(load_err)
`ifdef HOUR12_EN
        , .pm(pm)
`endif
    );

    typedef struct {
        logic [7:0] hh, mm, ss;
        logic       sec, day, err, pm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_h = 0, m_m = 0, m_s = 0;
    logic m_stbq = 1'b1;
    logic stb_lvl = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input int lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (from_bcd(v) <= lim);
    endfunction

    // One clock: drive inputs, predict, push; after the edge pop and compare.
    task automatic step(input logic rst, input logic stb, input logic hld, input logic ld,
                        input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
        exp_t e;
        exp_t got;
        logic rise;
        logic ok;
        @(negedge CLK100MHZ);
        reset = rst; clk_stb = stb; hold = hld; load = ld;
        load_hh = lh; load_mm = lm; load_ss = ls;
        stb_lvl = stb;
        e.sec = 1'b0; e.day = 1'b0; e.err = 1'b0;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_stbq = 1'b1;
        end else begin
            rise   = stb & ~m_stbq;
            m_stbq = stb;
            ok     = bcd_ok(lh, 23) && bcd_ok(lm, 59) && bcd_ok(ls, 59);
            e.sec  = rise;
            e.err  = ld & ~ok;
            if (ld && ok) begin
                m_h = from_bcd(lh); m_m = from_bcd(lm); m_s = from_bcd(ls);
            end else if (rise && !hld) begin
                m_s++;
                if (m_s == 60) begin
                    m_s = 0; m_m++;
                    if (m_m == 60) begin
                        m_m = 0; m_h++;
                        if (m_h == 24) begin
                            m_h = 0; e.day = 1'b1;
                        end
                    end
                end
            end
        end
        e.mm = to_bcd(m_m);
        e.ss = to_bcd(m_s);
        e.pm = (m_h >= 12);
`ifdef HOUR12_EN
        e.hh = to_bcd((m_h % 12 == 0) ? 12 : m_h % 12);
`else
        e.hh = to_bcd(m_h);
`endif
        sb.push_back(e);
        @(posedge CLK100MHZ);
        #1;
        got = sb.pop_front();
        check("hh", hh, got.hh);
        check("mm", mm, got.mm);
        check("ss", ss, got.ss);
        check("sec_tick", sec_tick, got.sec);
        check("day_roll", day_roll, got.day);
        check("load_err", load_err, got.err);
`ifdef HOUR12_EN
        check("pm", pm, got.pm);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, stb_lvl, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic sec_edge(input logic hld);
        step(1'b0, 1'b0, hld, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b0, hld, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, hld, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, hld, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        step(1'b0, stb_lvl, 1'b0, 1'b1, h, m, s);
        idle(1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with strobe high, release: no tick until a fresh 0->1.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle(4);
        sec_edge(1'b0);

        // Day wrap.
        set_time(8'h23, 8'h59, 8'h58);
        sec_edge(1'b0);
        sec_edge(1'b0);

        // Nibble carries into the minute.
        set_time(8'h00, 8'h09, 8'h59);
        sec_edge(1'b0);

        // Hold: ticks continue, time frozen.
        for (int i = 0; i < 3; i++)
            sec_edge(1'b1);
        sec_edge(1'b0);

        // Rejected loads, alone and coincident with a rise.
        set_time(8'h24, 8'h00, 8'h00);
        set_time(8'h12, 8'h5A, 8'h00);
        set_time(8'h05, 8'h60, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h1F, 8'h00, 8'h00);
        // Valid load wins over a coincident rise.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 8'h15, 8'h30);
        idle(2);
        // Valid load during hold.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 8'h00, 8'h00);

        // Reset mid-second with a rising strobe: edge discarded.
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle(3);
        sec_edge(1'b0);

        // Hour presentation points (12 h mapping when enabled).
        set_time(8'h00, 8'h00, 8'h00);
        set_time(8'h12, 8'h30, 8'h00);
        set_time(8'h13, 8'h00, 8'h00);
        set_time(8'h20, 8'h00, 8'h00);
        set_time(8'h22, 8'h00, 8'h00);
        set_time(8'h11, 8'h59, 8'h59);
        sec_edge(1'b0);

        // Random mix of strobe, hold, loads and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic       r_rst, r_stb, r_hld, r_ld;
            logic [7:0] r_h, r_m, r_s;
            r_rst = ($urandom_range(0, 63) == 0);
            r_stb = $urandom_range(0, 1) == 1;
            r_hld = ($urandom_range(0, 3) == 0);
            r_ld  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r_h = 8'($urandom_range(0, 255));
                r_m = 8'($urandom_range(0, 255));
                r_s = 8'($urandom_range(0, 255));
            end else begin
                r_h = to_bcd($urandom_range(0, 23));
                r_m = to_bcd($urandom_range(58, 59));
                r_s = to_bcd($urandom_range(55, 59));
            end
            step(r_rst, r_stb, r_hld, r_ld, r_h, r_m, r_s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
